// File: rtl/nco_pkg.sv
// nco_pkg: shared types and constants for the NCO and its CORDIC neighbours
package nco_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int ANGLE_W = 16;
  localparam logic [ANGLE_W-1:0] QUARTER_TURN = 16'h4000;
  localparam int DEFAULT_CORDIC_LAT = 17;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: N-deep 1-bit shift register with async active-low reset
module valid_delay_line #(
  parameter int N = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    sr <= !rst_n ? '0 : {sr[N-2:0], d};
  assign q = sr[N-1];
endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase-accumulator NCO with linear chirp and CORDIC-aligned valid
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CORDIC_LAT = DEFAULT_CORDIC_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [ACC_W-1:0]   ftw_start,
  input  logic [ACC_W-1:0]   ftw_step,
  input  logic [ACC_W-1:0]   ftw_stop,
  input  logic [ANGLE_W-1:0] phase_off,
  input  logic               sweep_en,
  input  logic               sweep_wrap,
  output logic [ANGLE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               cordic_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic               wrap_pulse
);
  localparam int CW = $clog2(CORDIC_LAT + 1);
  state_t state, state_n;
  logic [ACC_W-1:0] acc, ftw, start_q, step_q, stop_q;
  logic [ANGLE_W-1:0] off_q;
  logic en_q, wrap_q;
  logic [CW-1:0] cnt;
  logic [ACC_W:0] nxt;
  assign nxt = {1'b0, ftw} + {1'b0, step_q};
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    state <= !rst_n ? IDLE : state_n;
  always_comb
    state_n = (state == IDLE && start && !stop) ? RUN :
              (state == RUN && stop) ? DRAIN :
              (state == DRAIN && cnt == CW'(1)) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc         <= '0;
      ftw         <= '0;
      start_q     <= '0;
      step_q      <= '0;
      stop_q      <= '0;
      off_q       <= '0;
      en_q        <= 1'b0;
      wrap_q      <= 1'b0;
      cnt         <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      sweep_done  <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (state == IDLE && start && !stop) begin
        start_q    <= ftw_start;
        step_q     <= ftw_step;
        stop_q     <= ftw_stop;
        off_q      <= phase_off;
        en_q       <= sweep_en;
        wrap_q     <= sweep_wrap;
        acc        <= '0;
        ftw        <= ftw_start;
        sweep_done <= 1'b0;
      end else if (state == RUN && stop) begin
        phase_valid <= 1'b0;
        cnt         <= CW'(CORDIC_LAT);
      end else if (state == RUN) begin
        phase_out   <= acc[ACC_W-1 -: ANGLE_W] + off_q;
        phase_valid <= 1'b1;
        acc         <= acc + ftw;
        if (en_q) begin
          if (nxt > {1'b0, stop_q}) begin
            ftw        <= wrap_q ? start_q : stop_q;
            wrap_pulse <= wrap_q;
            sweep_done <= sweep_done | !wrap_q;
          end else begin
            ftw <= nxt[ACC_W-1:0];
          end
        end
      end else if (state == DRAIN) begin
        cnt <= cnt - CW'(1);
      end
    end
  valid_delay_line #(.N(CORDIC_LAT)) u_vdl (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (phase_valid),
    .q    (cordic_valid)
  );
endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen: table-driven directed checks plus hand sequences for the NCO
module tb_nco_phase_gen;
  import nco_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] ftw_start = '0, ftw_step = '0, ftw_stop = '0;
  logic [15:0] phase_off = '0;
  logic sweep_en = 1'b0, sweep_wrap = 1'b0;
  logic [15:0] phase_out;
  logic phase_valid, cordic_valid, busy, sweep_done, wrap_pulse;
  int n_tests = 0, n_fail = 0;

  nco_phase_gen #(.ACC_W(32), .CORDIC_LAT(DEFAULT_CORDIC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ftw_start(ftw_start), .ftw_step(ftw_step), .ftw_stop(ftw_stop),
    .phase_off(phase_off), .sweep_en(sweep_en), .sweep_wrap(sweep_wrap),
    .phase_out(phase_out), .phase_valid(phase_valid), .cordic_valid(cordic_valid),
    .busy(busy), .sweep_done(sweep_done), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fs, fst, fsp;
    logic [15:0] off;
    logic en, wr;
    logic [4:0][15:0] ph;
    int di, wi;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic cfg(input logic [31:0] fs, fst, fsp, input logic [15:0] off, input logic en, wr);
    ftw_start = fs;
    ftw_step = fst;
    ftw_stop = fsp;
    phase_off = off;
    sweep_en = en;
    sweep_wrap = wr;
  endtask

  task automatic scramble();
    cfg($urandom, $urandom, $urandom, 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kb;
    logic cv_prev, cv_at_idle;
    vecs[0] = '{fs:32'h0100_0000, fst:0, fsp:0, off:16'h0000, en:0, wr:0,
                ph:{16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000}, di:-1, wi:-1};
    vecs[1] = '{fs:32'h4000_0000, fst:0, fsp:0, off:16'h1000, en:0, wr:0,
                ph:{16'h1000, 16'hD000, 16'h9000, 16'h5000, 16'h1000}, di:-1, wi:-1};
    vecs[2] = '{fs:32'h0001_0000, fst:32'h0001_0000, fsp:32'h0003_8000, off:16'h0000, en:1, wr:0,
                ph:{16'h0009, 16'h0006, 16'h0003, 16'h0001, 16'h0000}, di:2, wi:-1};
    vecs[3] = '{fs:32'h0001_0000, fst:32'h0001_0000, fsp:32'h0003_8000, off:16'h0000, en:1, wr:1,
                ph:{16'h0007, 16'h0006, 16'h0003, 16'h0001, 16'h0000}, di:-1, wi:2};
    vecs[4] = '{fs:32'h0001_0000, fst:0, fsp:0, off:QUARTER_TURN, en:0, wr:0,
                ph:{16'h4004, 16'h4003, 16'h4002, 16'h4001, 16'h4000}, di:-1, wi:-1};

    do_reset();
    chk("rst_phase_out", 32'(phase_out), 0);
    chk("rst_phase_valid", 32'(phase_valid), 0);
    chk("rst_cordic_valid", 32'(cordic_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sweep_done", 32'(sweep_done), 0);
    chk("rst_wrap_pulse", 32'(wrap_pulse), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg(vecs[v].fs, vecs[v].fst, vecs[v].fsp, vecs[v].off, vecs[v].en, vecs[v].wr);
      start = 1'b1;
      tick();
      start = 1'b0;
      scramble();
      chk($sformatf("v%0d_busy_after_start", v), 32'(busy), 1);
      chk($sformatf("v%0d_valid_after_start", v), 32'(phase_valid), 0);
      for (int n = 0; n < 5; n++) begin
        tick();
        chk($sformatf("v%0d_s%0d_phase", v, n), 32'(phase_out), 32'(vecs[v].ph[n]));
        chk($sformatf("v%0d_s%0d_valid", v, n), 32'(phase_valid), 1);
        chk($sformatf("v%0d_s%0d_done", v, n), 32'(sweep_done), 32'(vecs[v].di >= 0 && n >= vecs[v].di));
        chk($sformatf("v%0d_s%0d_wrap", v, n), 32'(wrap_pulse), 32'(n == vecs[v].wi));
      end
    end

    do_reset();
    cfg(32'h0100_0000, 0, 0, 16'h0000, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lat_valid_rise", 32'(phase_valid), 1);
    chk("lat_cordic_low", 32'(cordic_valid), 0);
    k = 0;
    while (!cordic_valid && k < 40) begin
      tick();
      k++;
    end
    chk("lat_cordic_cycles", k, 17);
    repeat (3) tick();
    chk("run_phase_before_stop", 32'(phase_out), 32'h1400);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid_low", 32'(phase_valid), 0);
    chk("stop_busy", 32'(busy), 1);
    chk("stop_phase_hold", 32'(phase_out), 32'h1400);
    chk("stop_cordic_still_high", 32'(cordic_valid), 1);
    kb = 0;
    cv_prev = cordic_valid;
    cv_at_idle = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      start = (i == 5);
      cv_prev = cordic_valid;
      tick();
      if (!busy) begin
        kb = i;
        cv_at_idle = cordic_valid;
        break;
      end
    end
    start = 1'b0;
    chk("drain_busy_cycles", kb, 17);
    chk("drain_cordic_fall", 32'(cv_at_idle), 0);
    chk("drain_cordic_prev", 32'(cv_prev), 1);
    repeat (2) tick();
    chk("drain_start_ignored_busy", 32'(busy), 0);
    chk("drain_start_ignored_valid", 32'(phase_valid), 0);

    do_reset();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", 32'(busy), 0);
    tick();
    chk("start_stop_valid", 32'(phase_valid), 0);

    do_reset();
    cfg(32'h0100_0000, 0, 0, 16'h1234, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid_run_phase", 32'(phase_out), 32'h1434);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 32'(phase_out), 0);
    chk("async_rst_valid", 32'(phase_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_phase", 32'(phase_out), 32'h1234);
    chk("restart_valid", 32'(phase_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
